elevator_ctrl: RTL and testbench
================================

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter MOVE_TICKS, default 3, ticks to travel one floor (legal 1..7).
REQ-002 Parameter DOOR_TICKS, default 4, ticks door stays open (legal 1..7).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tick  input  1  one-cycle timing enable pulse (nominally 1 Hz), synchronous to clk.
REQ-006 btn_req  input  8  per-floor request pulses, bit n = floor n.
REQ-007 floor  output  3  current floor, 0..7.
REQ-008 countdown  output  3  ticks remaining in current move/door phase; 0 in IDLE.
REQ-009 floor_btn  output  8  latched pending requests, bit n = floor n.
REQ-010 status  output  4  one-hot state: bit0 IDLE, bit1 UP, bit2 DOWN, bit3 DOOR.

Function
REQ-011 SHALL set floor_btn[n] on the cycle after btn_req[n]=1, held until served; multiple bits may set in one cycle.
REQ-012 SHALL implement states IDLE, UP, DOWN, DOOR; status reflects state, registered.
REQ-013 SHALL keep a direction register dir (up/down), updated on every entry to UP or DOWN.
REQ-014 IDLE: pending at current floor -> DOOR, countdown=DOOR_TICKS, that bit cleared; else pending in dir -> move in dir; else pending opposite -> move opposite; else stay IDLE.
REQ-015 Entering UP/DOWN SHALL load countdown=MOVE_TICKS.
REQ-016 UP/DOWN: each tick decrements countdown; tick with countdown=1 is arrival: floor +/-1, same edge.
REQ-017 Arrival with pending at new floor -> DOOR, countdown=DOOR_TICKS, bit cleared; else pending further in same direction -> stay, reload MOVE_TICKS; else -> IDLE, countdown=0.
REQ-018 floor SHALL never leave 0..7; UP is never entered at floor 7 nor DOWN at floor 0.
REQ-019 DOOR: each tick decrements; tick with countdown=1 -> IDLE, countdown=0.
REQ-020 DOOR: btn_req for current floor SHALL reload countdown=DOOR_TICKS and not set floor_btn.
REQ-021 Same-cycle set and clear of one floor_btn bit (request at floor being served): clear wins.
REQ-022 tick in IDLE SHALL have no effect; btn_req is never lost in any state.
REQ-023 Latency: btn_req at cycle N -> floor_btn at N+1 -> state/status change at N+2 from IDLE.

Reset
REQ-024 On rst: floor=0, countdown=0, floor_btn=0, status=4'b0001 (IDLE), dir=up, immediately and asynchronously, including mid-move or mid-door.
REQ-025 First tick/btn_req honoured on first rising clk edge after rst deasserts.

Structure
REQ-026 Shared package elevator_pkg SHALL hold state enum, status one-hot encodings, NFLOORS=8, floor/countdown widths.
REQ-027 Sub-module elev_req_reg SHALL hold floor_btn (set/clear logic) and produce here/above/below flags relative to floor; elevator_ctrl holds FSM, floor, countdown, dir.
REQ-028 Outputs SHALL connect directly to Display floor, countdown, floor_btn, status inputs.

Verification (MOVE_TICKS=3, DOOR_TICKS=4)
REQ-029 Reset, btn_req=8'h08 -> status UP; floor 1,2,3 after ticks 3,6,9; at floor 3 status DOOR, countdown 4, floor_btn=0; IDLE after 4 more ticks.
REQ-030 IDLE at floor 0, btn_req=8'h01 -> DOOR at N+2, countdown 4, floor_btn stays 0.
REQ-031 From floor 0 IDLE, btn_req=8'h24 -> DOOR at floor 2 (bit2 cleared), then UP, DOOR at floor 5, floor_btn=0.
REQ-032 IDLE at floor 4 dir up, btn_req=8'h42 same cycle -> UP to 6 first, door, then DOWN to 1.
REQ-033 DOOR at floor 2, countdown 1, btn_req=8'h04 before tick -> countdown reloads 4, door remains open.
REQ-034 rst pulse while UP between floors 3 and 4 with floor_btn=8'h80 -> outputs immediately floor 0, countdown 0, floor_btn 0, status 4'b0001.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the eight-floor elevator controller.
// The state enum values double as the one-hot status word.
package elevator_pkg;

   localparam int NFLOORS = 8;
   localparam int FLOOR_W = 3;
   localparam int CNT_W   = 3;

   localparam logic [3:0] STATUS_IDLE = 4'b0001;
   localparam logic [3:0] STATUS_UP   = 4'b0010;
   localparam logic [3:0] STATUS_DOWN = 4'b0100;
   localparam logic [3:0] STATUS_DOOR = 4'b1000;

   typedef enum logic [3:0] {
      ST_IDLE = STATUS_IDLE,
      ST_UP   = STATUS_UP,
      ST_DOWN = STATUS_DOWN,
      ST_DOOR = STATUS_DOOR
   } state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   function automatic logic [NFLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
      return {{(NFLOORS-1){1'b0}}, 1'b1} << f;
   endfunction

endpackage

// File: rtl/elev_req_reg.sv
// Pending-request register with here/above/below flags relative to a query floor.
// Clear has priority over set for the same bit.
module elev_req_reg
   import elevator_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NFLOORS-1:0] i_set,
   input  logic [NFLOORS-1:0] i_clr,
   input  logic [FLOOR_W-1:0] i_qfloor,
   output logic [NFLOORS-1:0] o_floor_btn,
   output logic               o_here,
   output logic               o_above,
   output logic               o_below
);

   logic [NFLOORS-1:0] r_btn;
   logic [NFLOORS-1:0] w_above_mask;
   logic [NFLOORS-1:0] w_below_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_btn <= '0;
      end else begin
         r_btn <= (r_btn | i_set) & ~i_clr;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NFLOORS; gi++) begin : g_mask
         assign w_above_mask[gi] = (FLOOR_W'(gi) > i_qfloor);
         assign w_below_mask[gi] = (FLOOR_W'(gi) < i_qfloor);
      end
   endgenerate

   assign o_floor_btn = r_btn;
   assign o_here      = r_btn[i_qfloor];
   assign o_above     = |(r_btn & w_above_mask);
   assign o_below     = |(r_btn & w_below_mask);

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator controller: IDLE/UP/DOWN/DOOR FSM, floor position, phase countdown
// and travel direction; pending requests live in elev_req_reg.
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int MOVE_TICKS = 3,
   parameter int DOOR_TICKS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic [NFLOORS-1:0] btn_req,
   output logic [FLOOR_W-1:0] floor,
   output logic [CNT_W-1:0]   countdown,
   output logic [NFLOORS-1:0] floor_btn,
   output logic [3:0]         status
);

   localparam logic [CNT_W-1:0] MOVE_CNT = CNT_W'(MOVE_TICKS);
   localparam logic [CNT_W-1:0] DOOR_CNT = CNT_W'(DOOR_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);

   state_t             r_state, w_state_next;
   logic [FLOOR_W-1:0] r_floor, w_floor_next;
   logic [CNT_W-1:0]   r_cnt, w_cnt_next;
   dir_t               r_dir, w_dir_next;

   logic [FLOOR_W-1:0] w_qfloor;
   logic [NFLOORS-1:0] w_set;
   logic [NFLOORS-1:0] w_clr;
   logic [NFLOORS-1:0] w_floor_btn;
   logic               w_here;
   logic               w_above;
   logic               w_below;

   // While moving, the flags describe the floor we are about to arrive at.
   always_comb begin
      w_qfloor = r_floor;
      if (r_state == ST_UP) begin
         w_qfloor = r_floor + FLOOR_ONE;
      end else if (r_state == ST_DOWN) begin
         w_qfloor = r_floor - FLOOR_ONE;
      end
   end

   always_comb begin
      w_set = btn_req;
      if (r_state == ST_DOOR) begin
         w_set[r_floor] = 1'b0;
      end
   end

   elev_req_reg u_req (
      .clk         (clk),
      .rst         (rst),
      .i_set       (w_set),
      .i_clr       (w_clr),
      .i_qfloor    (w_qfloor),
      .o_floor_btn (w_floor_btn),
      .o_here      (w_here),
      .o_above     (w_above),
      .o_below     (w_below)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_floor <= '0;
         r_cnt   <= '0;
         r_dir   <= DIR_UP;
      end else begin
         r_state <= w_state_next;
         r_floor <= w_floor_next;
         r_cnt   <= w_cnt_next;
         r_dir   <= w_dir_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_floor_next = r_floor;
      w_cnt_next   = r_cnt;
      w_dir_next   = r_dir;
      w_clr        = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_here) begin
               w_state_next = ST_DOOR;
               w_cnt_next   = DOOR_CNT;
               w_clr        = floor_onehot(r_floor);
            end else if ((r_dir == DIR_UP && w_above) || (r_dir == DIR_DOWN && !w_below && w_above)) begin
               w_state_next = ST_UP;
               w_dir_next   = DIR_UP;
               w_cnt_next   = MOVE_CNT;
            end else if (w_below) begin
               w_state_next = ST_DOWN;
               w_dir_next   = DIR_DOWN;
               w_cnt_next   = MOVE_CNT;
            end
         end
         ST_UP, ST_DOWN: begin
            if (tick) begin
               if (r_cnt <= CNT_ONE) begin
                  w_floor_next = w_qfloor;
                  if (w_here) begin
                     w_state_next = ST_DOOR;
                     w_cnt_next   = DOOR_CNT;
                     w_clr        = floor_onehot(w_qfloor);
                  end else if ((r_state == ST_UP) ? w_above : w_below) begin
                     w_cnt_next = MOVE_CNT;
                  end else begin
                     w_state_next = ST_IDLE;
                     w_cnt_next   = '0;
                  end
               end else begin
                  w_cnt_next = r_cnt - CNT_ONE;
               end
            end
         end
         ST_DOOR: begin
            // A call from the landing we are serving keeps the door open.
            if (btn_req[r_floor]) begin
               w_cnt_next = DOOR_CNT;
            end else if (tick) begin
               if (r_cnt <= CNT_ONE) begin
                  w_state_next = ST_IDLE;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt - CNT_ONE;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign floor     = r_floor;
   assign countdown = r_cnt;
   assign floor_btn = w_floor_btn;
   assign status    = r_state;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: each floor/status change is popped from an
// expected-event queue and compared against the full output snapshot.
module tb_elevator_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic [7:0] btn_req = 8'h00;
   logic [2:0] floor;
   logic [2:0] countdown;
   logic [7:0] floor_btn;
   logic [3:0] status;

   localparam logic [3:0] S_IDLE = 4'b0001;
   localparam logic [3:0] S_UP   = 4'b0010;
   localparam logic [3:0] S_DOWN = 4'b0100;
   localparam logic [3:0] S_DOOR = 4'b1000;

   typedef struct packed {
      logic [2:0] fl;
      logic [2:0] cd;
      logic [7:0] btn;
      logic [3:0] st;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_events = 0;
   logic [6:0] prev_snap = {3'd0, S_IDLE};

   elevator_ctrl #(.MOVE_TICKS(3), .DOOR_TICKS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .btn_req   (btn_req),
      .floor     (floor),
      .countdown (countdown),
      .floor_btn (floor_btn),
      .status    (status)
   );

   always #5 clk = ~clk;

   task automatic expect_ev(input logic [2:0] f, input logic [2:0] c,
                            input logic [7:0] b, input logic [3:0] s);
      exp_t e;
      e.fl = f; e.cd = c; e.btn = b; e.st = s;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end else begin
         $display("check %s: %0h ok", name, act);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 tick = 1'b1;
         @(posedge clk); #1 tick = 1'b0;
      end
   endtask

   task automatic press(input logic [7:0] b);
      @(posedge clk); #1 btn_req = b;
      @(posedge clk); #1 btn_req = 8'h00;
   endtask

   // Monitor: a change of floor or status is one transaction.
   always @(negedge clk) begin
      exp_t e;
      if ({floor, status} !== prev_snap) begin
         prev_snap = {floor, status};
         n_checks++;
         n_events++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got floor=%0d cd=%0d btn=%02h st=%04b, expected none",
                     floor, countdown, floor_btn, status);
         end else begin
            e = exp_q.pop_front();
            if ({floor, countdown, floor_btn, status} !== e) begin
               n_fail++;
               $display("FAIL event_%0d: got floor=%0d cd=%0d btn=%02h st=%04b, expected floor=%0d cd=%0d btn=%02h st=%04b",
                        n_events, floor, countdown, floor_btn, status, e.fl, e.cd, e.btn, e.st);
            end else begin
               $display("event %0d: floor=%0d cd=%0d btn=%02h st=%04b ok",
                        n_events, floor, countdown, floor_btn, status);
            end
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2 rst = 1'b1;
      #20 rst = 1'b0;
      @(posedge clk); #1;
      check("reset_floor", 32'(floor), 32'd0);
      check("reset_countdown", 32'(countdown), 32'd0);
      check("reset_floor_btn", 32'(floor_btn), 32'h00);
      check("reset_status", 32'(status), 32'(S_IDLE));

      // Request at current floor: door opens two cycles after the press.
      expect_ev(3'd0, 3'd4, 8'h00, S_DOOR);
      expect_ev(3'd0, 3'd0, 8'h00, S_IDLE);
      press(8'h01);
      check("here_latch_btn", 32'(floor_btn), 32'h01);
      check("here_latch_status", 32'(status), 32'(S_IDLE));
      @(posedge clk); #1;
      check("here_door_btn_cleared", 32'(floor_btn), 32'h00);
      ticks(4);

      // Travel 0 -> 3.
      expect_ev(3'd0, 3'd3, 8'h08, S_UP);
      expect_ev(3'd1, 3'd3, 8'h08, S_UP);
      expect_ev(3'd2, 3'd3, 8'h08, S_UP);
      expect_ev(3'd3, 3'd4, 8'h00, S_DOOR);
      expect_ev(3'd3, 3'd0, 8'h00, S_IDLE);
      press(8'h08);
      check("up_latch_btn", 32'(floor_btn), 32'h08);
      ticks(2);
      check("up_mid_countdown", 32'(countdown), 32'd1);
      ticks(7);
      ticks(4);

      // Asynchronous reset while moving between floors 3 and 4.
      expect_ev(3'd3, 3'd3, 8'h80, S_UP);
      expect_ev(3'd0, 3'd0, 8'h00, S_IDLE);
      press(8'h80);
      ticks(1);
      check("pre_reset_countdown", 32'(countdown), 32'd2);
      #2 rst = 1'b1;
      #1;
      check("async_rst_floor", 32'(floor), 32'd0);
      check("async_rst_countdown", 32'(countdown), 32'd0);
      check("async_rst_floor_btn", 32'(floor_btn), 32'h00);
      check("async_rst_status", 32'(status), 32'(S_IDLE));
      @(posedge clk); #1 rst = 1'b0;

      // Two requests up; door reopen at floor 2; continue to 5.
      expect_ev(3'd0, 3'd3, 8'h24, S_UP);
      expect_ev(3'd1, 3'd3, 8'h24, S_UP);
      expect_ev(3'd2, 3'd4, 8'h20, S_DOOR);
      expect_ev(3'd2, 3'd0, 8'h20, S_IDLE);
      expect_ev(3'd2, 3'd3, 8'h20, S_UP);
      expect_ev(3'd3, 3'd3, 8'h20, S_UP);
      expect_ev(3'd4, 3'd3, 8'h20, S_UP);
      expect_ev(3'd5, 3'd4, 8'h00, S_DOOR);
      expect_ev(3'd5, 3'd0, 8'h00, S_IDLE);
      press(8'h24);
      ticks(6);
      ticks(3);
      check("door_cd_before_reopen", 32'(countdown), 32'd1);
      press(8'h04);
      check("door_reopen_countdown", 32'(countdown), 32'd4);
      check("door_reopen_btn", 32'(floor_btn), 32'h20);
      check("door_reopen_status", 32'(status), 32'(S_DOOR));
      ticks(4);
      ticks(9);
      ticks(4);

      // Back to floor 0, then up to 4 so direction is up.
      expect_ev(3'd0, 3'd0, 8'h00, S_IDLE);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      expect_ev(3'd0, 3'd3, 8'h10, S_UP);
      expect_ev(3'd1, 3'd3, 8'h10, S_UP);
      expect_ev(3'd2, 3'd3, 8'h10, S_UP);
      expect_ev(3'd3, 3'd3, 8'h10, S_UP);
      expect_ev(3'd4, 3'd4, 8'h00, S_DOOR);
      expect_ev(3'd4, 3'd0, 8'h00, S_IDLE);
      press(8'h10);
      ticks(12);
      ticks(4);

      // Requests above and below at once: serve 6 first, then 1.
      expect_ev(3'd4, 3'd3, 8'h42, S_UP);
      expect_ev(3'd5, 3'd3, 8'h42, S_UP);
      expect_ev(3'd6, 3'd4, 8'h02, S_DOOR);
      expect_ev(3'd6, 3'd0, 8'h02, S_IDLE);
      expect_ev(3'd6, 3'd3, 8'h02, S_DOWN);
      expect_ev(3'd5, 3'd3, 8'h02, S_DOWN);
      expect_ev(3'd4, 3'd3, 8'h02, S_DOWN);
      expect_ev(3'd3, 3'd3, 8'h02, S_DOWN);
      expect_ev(3'd2, 3'd3, 8'h02, S_DOWN);
      expect_ev(3'd1, 3'd4, 8'h00, S_DOOR);
      expect_ev(3'd1, 3'd0, 8'h00, S_IDLE);
      press(8'h42);
      ticks(6);
      ticks(4);
      ticks(15);
      ticks(4);

      // Ticks in IDLE change nothing.
      ticks(3);
      check("idle_tick_floor", 32'(floor), 32'd1);
      check("idle_tick_countdown", 32'(countdown), 32'd0);
      check("idle_tick_status", 32'(status), 32'(S_IDLE));

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
